pic_priority_core: RTL and testbench
====================================

# pic_priority_core

Parametrised, clocked successor to the 8259 combinational priority resolver. It holds IRR and ISR state for `NUM_IRQ` request lines and supports edge or level triggering. It resolves priority with fixed, automatic or specific rotation and runs the two-pulse INTA handshake toward the CPU interface. It sits between the IRQ input pins and the bus/control logic of the PIC, which owns IMR and the command decoding.

## Interface
- `NUM_IRQ`, 8, number of request channels; power of two, 2..32.
- `IDW`, $clog2(NUM_IRQ), channel-index width (derived).
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `irq_in` in NUM_IRQ: request lines, already synchronous to `clk`.
- `level_mode` in 1: 1 = level-triggered, 0 = rising-edge.
- `imr` in NUM_IRQ: mask; 1 = channel disabled.
- `auto_rotate` in 1: 1 = rotate on every non-specific EOI.
- `inta` in 1: acknowledge pulse, one cycle per pulse.
- `eoi` in 1: non-specific EOI pulse.
- `seoi` in 1: specific EOI pulse.
- `seoi_id` in IDW: channel cleared by `seoi`.
- `rot_set` in 1: specific-rotate pulse.
- `rot_id` in IDW: channel that becomes lowest priority on `rot_set`.
- `int_out` out 1: registered interrupt request to the CPU.
- `vec_valid` out 1: one-cycle strobe qualifying `vec_id`.
- `vec_id` out IDW: acknowledged channel index.
- `irr_out` out NUM_IRQ: IRR register.
- `isr_out` out NUM_IRQ: ISR register.
- `prio_base` out IDW: current highest-priority channel.

## Operation
- **Priority order:** `prio_base`, then `prio_base+1`, … up to `prio_base+NUM_IRQ-1`, all mod NUM_IRQ.
- **Edge mode:** `irq_prev` registers `irq_in`. An IRR bit is set on `irq_in & ~irq_prev`. It is cleared only by the first INTA of its own service.
- **Level mode:** the IRR bit follows `irq_in` every cycle. The first INTA clears it for that cycle only.
- **Candidate:** the highest-priority bit of `IRR & ~imr`, provided it is strictly higher priority than the highest-priority bit of `ISR & ~imr`. Masked ISR bits never block.
- **`int_out`:** registered "candidate exists" while the FSM is in IDLE; forced 0 in WAIT2.
- **FSM IDLE, on `inta`:**
  - With a candidate: latch the candidate id, set its ISR bit, clear its IRR bit, go to WAIT2.
  - Without a candidate (spurious): latch id NUM_IRQ-1, leave ISR and IRR unchanged, go to WAIT2.
- **FSM WAIT2, on `inta`:** drive `vec_valid`=1 and `vec_id`=latched id for one cycle, return to IDLE. There is no timeout. All other WAIT2 inputs except EOI and rotate are ignored.
- **Non-specific EOI:** clears the highest-priority set ISR bit, where priority is evaluated on the unmasked ISR. If `auto_rotate`=1, `prio_base` becomes cleared_id+1 mod NUM_IRQ. If ISR is empty, nothing changes, including no rotation.
- **Specific EOI:** clears ISR[`seoi_id`] and never rotates. If `eoi` and `seoi` arrive in the same cycle, `seoi` wins.
- **`rot_set`:** `prio_base` becomes `rot_id`+1 mod NUM_IRQ. It overrides an auto-rotate in the same cycle.
- **Simultaneous ISR set and clear:** the EOI clear is applied first, then the INTA set. If both target the same bit, the bit ends at 1.
- **Index arithmetic:** all index arithmetic is mod NUM_IRQ in IDW bits; `prio_base`+1 wraps NUM_IRQ-1 to 0.

## Timing
- **Reset values:** IRR, ISR, `irq_prev`, `prio_base`, `vec_id` = 0; `int_out`, `vec_valid` = 0; FSM = IDLE.
- **Edge at reset release:** because `irq_prev` resets to 0, a line already high when reset is released is treated as an edge.
- **Request latency:** `irq_in` sampled high at edge k → IRR set after k → `int_out`=1 after k+1.
- **First INTA:** sampled at edge k → ISR/IRR update and `int_out`=0 after k.
- **Second INTA:** sampled at edge m → `vec_valid`=1 during cycle m..m+1 only.
- **Back-to-back:** in IDLE after the second INTA, `int_out` reasserts one cycle later if a further candidate exists.
- **EOI and rotate:** visible in ISR and `prio_base` one cycle after the pulse. They may be issued in any FSM state.
- **Reset mid-handshake:** asserting reset during WAIT2 aborts the handshake; no `vec_valid` is produced.

## Test plan
- **Basic edge service:** N=8, edge mode, imr=0, pulse irq_in[3] → `int_out`=1 two cycles later. INTA, INTA → isr_out=0x08, irr_out=0, `vec_id`=3 with one `vec_valid` strobe. Then eoi → isr_out=0x00.
- **Nesting:** while ISR[5] is set, raise irq[6] → `int_out` stays 0. Raise irq[2] → `int_out`=1; after acks isr_out=0x24, `vec_id`=2.
- **Auto-rotate:** auto_rotate=1, service ch 4, then eoi → `prio_base`=5. Raise irq[4] and irq[5] together → `vec_id`=5. Then rot_set with rot_id=7 → `prio_base`=0.
- **Spurious:** raise irq[1], drop it in level mode before the first INTA → `vec_id`=7, ISR unchanged (0x00).
- **Masking and simultaneity:** imr=0x01 with irq[0] high → `int_out`=0. EOI and first INTA for the same channel in one cycle → ISR bit stays 1. `eoi`+`seoi`(id 2) with isr=0x05 → isr=0x01.
- **Reset mid-handshake:** assert `rst_n`=0 in WAIT2 → all outputs 0 and `prio_base`=0. With no INTA after release there is no `vec_valid`; a line already high at release raises `int_out` two cycles later.

Source files
------------

// File: rtl/pic_priority_core.sv
// pic_priority_core: clocked 8259-style priority resolver.
// Holds the request (IRR) and in-service (ISR) registers. Resolves priority
// from a rotatable base channel and runs the two-pulse INTA handshake.
module pic_priority_core #(
  parameter  int NUM_IRQ = 8,
  localparam int IDW     = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               level_mode,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               auto_rotate,
  input  logic               inta,
  input  logic               eoi,
  input  logic               seoi,
  input  logic [IDW-1:0]     seoi_id,
  input  logic               rot_set,
  input  logic [IDW-1:0]     rot_id,
  output logic               int_out,
  output logic               vec_valid,
  output logic [IDW-1:0]     vec_id,
  output logic [NUM_IRQ-1:0] irr_out,
  output logic [NUM_IRQ-1:0] isr_out,
  output logic [IDW-1:0]     prio_base
);

  typedef enum logic {IDLE, WAIT2} state_t;

  state_t             state, state_next;
  logic [NUM_IRQ-1:0] irr, irr_next;
  logic [NUM_IRQ-1:0] isr, isr_next;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [IDW-1:0]     base_next;
  logic [IDW-1:0]     ack_id, ack_next;
  logic [IDW-1:0]     vec_id_next;
  logic               vec_valid_next;
  logic               int_next;

  logic               irr_found, isr_found, any_found;
  logic [IDW-1:0]     irr_top, isr_top, any_top;
  logic [IDW-1:0]     irr_rank, isr_rank;
  logic               cand_valid;
  logic [NUM_IRQ-1:0] irr_clr, isr_set;

  // Scans from the base channel upward (wrapping) and returns {found, id}
  // of the first set bit, i.e. the highest-priority active channel.
  function automatic logic [IDW:0] find_top(input logic [NUM_IRQ-1:0] vec,
                                            input logic [IDW-1:0]     base);
    logic           found;
    logic [IDW-1:0] id;
    logic [IDW-1:0] idx;
    found = 1'b0;
    id    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      idx = base + IDW'(i);
      if (!found && vec[idx]) begin
        found = 1'b1;
        id    = idx;
      end
    end
    return {found, id};
  endfunction

  // Priority resolution: a pending unmasked request is a candidate only
  // when it outranks every unmasked in-service channel.
  always_comb begin
    {irr_found, irr_top} = find_top(irr & ~imr, prio_base);
    {isr_found, isr_top} = find_top(isr & ~imr, prio_base);
    {any_found, any_top} = find_top(isr, prio_base);
    irr_rank   = irr_top - prio_base;
    isr_rank   = isr_top - prio_base;
    cand_valid = irr_found && (!isr_found || (irr_rank < isr_rank));
  end

  // Handshake FSM, EOI/rotation and register next-state. The EOI clear is
  // applied before the INTA set so that the same bit ends up set.
  always_comb begin
    state_next     = state;
    ack_next       = ack_id;
    vec_id_next    = vec_id;
    vec_valid_next = 1'b0;
    base_next      = prio_base;
    irr_clr        = '0;
    isr_set        = '0;
    isr_next       = isr;

    if (seoi) begin
      isr_next[seoi_id] = 1'b0;
    end else if (eoi && any_found) begin
      isr_next[any_top] = 1'b0;
      if (auto_rotate) begin
        base_next = any_top + IDW'(1);
      end
    end

    if (rot_set) begin
      base_next = rot_id + IDW'(1);
    end

    case (state)
      IDLE: begin
        if (inta) begin
          state_next = WAIT2;
          if (cand_valid) begin
            ack_next         = irr_top;
            isr_set[irr_top] = 1'b1;
            irr_clr[irr_top] = 1'b1;
          end else begin
            ack_next = IDW'(NUM_IRQ - 1);
          end
        end
      end
      WAIT2: begin
        if (inta) begin
          state_next     = IDLE;
          vec_valid_next = 1'b1;
          vec_id_next    = ack_id;
        end
      end
      default: state_next = IDLE;
    endcase

    isr_next = isr_next | isr_set;

    if (level_mode) begin
      irr_next = irq_in & ~irr_clr;
    end else begin
      irr_next = (irr & ~irr_clr) | (irq_in & ~irq_prev);
    end

    int_next = (state_next == IDLE) && cand_valid;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irr       <= '0;
      isr       <= '0;
      irq_prev  <= '0;
      prio_base <= '0;
      ack_id    <= '0;
      vec_id    <= '0;
      vec_valid <= 1'b0;
      int_out   <= 1'b0;
    end else begin
      state     <= state_next;
      irr       <= irr_next;
      isr       <= isr_next;
      irq_prev  <= irq_in;
      prio_base <= base_next;
      ack_id    <= ack_next;
      vec_id    <= vec_id_next;
      vec_valid <= vec_valid_next;
      int_out   <= int_next;
    end
  end

  assign irr_out = irr;
  assign isr_out = isr;

endmodule

// File: tb/tb_pic_priority_core.sv
// Testbench for pic_priority_core: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a behavioural model.
module tb_pic_priority_core;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic         level_mode = 1'b0;
  logic [N-1:0] imr = '0;
  logic         auto_rotate = 1'b0;
  logic         inta = 1'b0;
  logic         eoi = 1'b0;
  logic         seoi = 1'b0;
  logic [2:0]   seoi_id = '0;
  logic         rot_set = 1'b0;
  logic [2:0]   rot_id = '0;
  logic         int_out;
  logic         vec_valid;
  logic [2:0]   vec_id;
  logic [N-1:0] irr_out;
  logic [N-1:0] isr_out;
  logic [2:0]   prio_base;

  int check_count = 0;
  int error_count = 0;

  // Reference model state
  bit [N-1:0] m_irr, m_isr, m_prev;
  int         m_base, m_ack, m_vid;
  bit         m_wait, m_int, m_vv;

  pic_priority_core #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .level_mode(level_mode),
    .imr(imr), .auto_rotate(auto_rotate), .inta(inta), .eoi(eoi),
    .seoi(seoi), .seoi_id(seoi_id), .rot_set(rot_set), .rot_id(rot_id),
    .int_out(int_out), .vec_valid(vec_valid), .vec_id(vec_id),
    .irr_out(irr_out), .isr_out(isr_out), .prio_base(prio_base)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // First set channel walking from base upward; -1 when none.
  function automatic int top_of(input bit [N-1:0] v, input int base);
    for (int r = 0; r < N; r++)
      if (v[(base + r) % N]) return (base + r) % N;
    return -1;
  endfunction

  function automatic int rank_of(input int id, input int base);
    return (id - base + N) % N;
  endfunction

  task automatic model_reset();
    m_irr = '0; m_isr = '0; m_prev = '0;
    m_base = 0; m_ack = 0; m_vid = 0;
    m_wait = 0; m_int = 0; m_vv = 0;
  endtask

  // One clock of the specified behaviour using the current inputs.
  task automatic model_step();
    int ci, si, ei, base_n, ack_n;
    bit cand, wait_n;
    bit [N-1:0] isr_n, clr;
    ci = top_of(m_irr & ~imr, m_base);
    si = top_of(m_isr & ~imr, m_base);
    cand = (ci >= 0) && (si < 0 || rank_of(ci, m_base) < rank_of(si, m_base));
    isr_n = m_isr; base_n = m_base; clr = '0;
    wait_n = m_wait; ack_n = m_ack;
    if (seoi) isr_n[seoi_id] = 1'b0;
    else if (eoi) begin
      ei = top_of(m_isr, m_base);
      if (ei >= 0) begin
        isr_n[ei] = 1'b0;
        if (auto_rotate) base_n = (ei + 1) % N;
      end
    end
    if (rot_set) base_n = (int'(rot_id) + 1) % N;
    m_vv = 1'b0;
    if (!m_wait && inta) begin
      wait_n = 1'b1;
      if (cand) begin
        ack_n = ci; isr_n[ci] = 1'b1; clr[ci] = 1'b1;
      end else ack_n = N - 1;
    end else if (m_wait && inta) begin
      wait_n = 1'b0; m_vv = 1'b1; m_vid = m_ack;
    end
    if (level_mode) m_irr = irq_in & ~clr;
    else m_irr = (m_irr & ~clr) | (irq_in & ~m_prev);
    m_int = !wait_n && cand;
    m_isr = isr_n; m_base = base_n; m_wait = wait_n; m_ack = ack_n;
    m_prev = irq_in;
  endtask

  task automatic compare_all(input string tag);
    checkOutput({tag, ".int_out"}, int_out, m_int);
    checkOutput({tag, ".vec_valid"}, vec_valid, m_vv);
    checkOutput({tag, ".vec_id"}, vec_id, m_vid);
    checkOutput({tag, ".irr"}, irr_out, m_irr);
    checkOutput({tag, ".isr"}, isr_out, m_isr);
    checkOutput({tag, ".prio_base"}, prio_base, m_base);
  endtask

  // One clock: advance model, sample #1 after the edge, clear pulses.
  task automatic applyStimulus(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
    inta = 0; eoi = 0; seoi = 0; rot_set = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare_all("release");
  endtask

  task automatic pulse_irq(input logic [N-1:0] bits);
    irq_in = bits;
    applyStimulus("irq_hi");
    irq_in = '0;
    applyStimulus("irq_lo");
  endtask

  task automatic ack_twice();
    inta = 1; applyStimulus("inta1");
    inta = 1; applyStimulus("inta2");
  endtask

  initial begin
    // Basic edge service
    do_reset();
    pulse_irq(8'h08);
    checkOutput("basic_int", int_out, 1);
    inta = 1; applyStimulus("b_inta1");
    checkOutput("basic_isr", isr_out, 8'h08);
    checkOutput("basic_irr", irr_out, 8'h00);
    checkOutput("basic_int_low", int_out, 0);
    inta = 1; applyStimulus("b_inta2");
    checkOutput("basic_vv", vec_valid, 1);
    checkOutput("basic_vid", vec_id, 3);
    applyStimulus("b_idle");
    checkOutput("basic_vv_once", vec_valid, 0);
    eoi = 1; applyStimulus("b_eoi");
    checkOutput("basic_eoi", isr_out, 8'h00);

    // Nesting
    do_reset();
    pulse_irq(8'h20);
    ack_twice();
    pulse_irq(8'h40);
    checkOutput("nest_blocked", int_out, 0);
    pulse_irq(8'h04);
    checkOutput("nest_int", int_out, 1);
    inta = 1; applyStimulus("n_inta1");
    inta = 1; applyStimulus("n_inta2");
    checkOutput("nest_vid", vec_id, 2);
    checkOutput("nest_isr", isr_out, 8'h24);

    // Auto-rotate and specific rotate
    do_reset();
    auto_rotate = 1;
    pulse_irq(8'h10);
    ack_twice();
    eoi = 1; applyStimulus("r_eoi");
    checkOutput("rot_base5", prio_base, 5);
    pulse_irq(8'h30);
    inta = 1; applyStimulus("r_inta1");
    inta = 1; applyStimulus("r_inta2");
    checkOutput("rot_vid5", vec_id, 5);
    rot_set = 1; rot_id = 7; applyStimulus("r_set");
    checkOutput("rot_base0", prio_base, 0);
    auto_rotate = 0;

    // Spurious in level mode
    do_reset();
    level_mode = 1;
    irq_in = 8'h02; applyStimulus("s_hi");
    applyStimulus("s_hold");
    irq_in = 8'h00; applyStimulus("s_drop");
    inta = 1; applyStimulus("s_inta1");
    inta = 1; applyStimulus("s_inta2");
    checkOutput("spur_vid", vec_id, 7);
    checkOutput("spur_isr", isr_out, 8'h00);
    level_mode = 0;

    // Masking, then specific EOI and first INTA on the same channel
    do_reset();
    imr = 8'h01; irq_in = 8'h01;
    applyStimulus("m_hi");
    applyStimulus("m_hold");
    checkOutput("mask_int", int_out, 0);
    imr = 8'h00; irq_in = 8'h00;
    applyStimulus("m_unmask");
    seoi = 1; seoi_id = 0; inta = 1; applyStimulus("m_same");
    checkOutput("same_bit_isr", isr_out, 8'h01);
    inta = 1; applyStimulus("m_inta2");

    // EOI and specific EOI together: specific wins
    do_reset();
    pulse_irq(8'h04);
    ack_twice();
    pulse_irq(8'h01);
    ack_twice();
    checkOutput("isr05", isr_out, 8'h05);
    eoi = 1; seoi = 1; seoi_id = 2; applyStimulus("e_both");
    checkOutput("seoi_wins", isr_out, 8'h01);

    // Reset in the middle of the handshake
    do_reset();
    rot_set = 1; rot_id = 4; applyStimulus("x_rot");
    pulse_irq(8'h02);
    inta = 1; applyStimulus("x_inta1");
    irq_in = 8'h08;
    rst_n = 1'b0;
    #2;
    model_reset();
    checkOutput("rst_int", int_out, 0);
    checkOutput("rst_vv", vec_valid, 0);
    checkOutput("rst_isr", isr_out, 0);
    checkOutput("rst_irr", irr_out, 0);
    checkOutput("rst_base", prio_base, 0);
    checkOutput("rst_vid", vec_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("x_edge");
    applyStimulus("x_int");
    checkOutput("rst_edge_int", int_out, 1);
    checkOutput("rst_no_vv", vec_valid, 0);
    irq_in = '0;

    // Randomized traffic
    for (int cfg = 0; cfg < 6; cfg++) begin
      level_mode  = 1'($urandom % 2);
      auto_rotate = 1'($urandom % 2);
      imr = ($urandom % 3 == 0) ? N'($urandom & $urandom) : '0;
      for (int c = 0; c < 300; c++) begin
        if (level_mode) irq_in = irq_in ^ N'($urandom & $urandom & $urandom);
        else irq_in = N'($urandom & $urandom & $urandom);
        inta    = ($urandom % 4 == 0);
        eoi     = ($urandom % 8 == 0);
        seoi    = ($urandom % 16 == 0);
        seoi_id = 3'($urandom);
        rot_set = ($urandom % 32 == 0);
        rot_id  = 3'($urandom);
        if ($urandom % 64 == 0) imr = N'($urandom & $urandom);
        applyStimulus("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
